// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] PC_INC    = 64'd4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries; clear empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  fetch_entry_t  mem [DEPTH];

  logic push_ok;
  logic pop_ok;

  // Over/underflow is blocked here as well so a misbehaving upstream cannot corrupt the pointers.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; clear behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PW'(1);
      if (pop_ok)  head <= head + PW'(1);
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CW'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[tail] <= push_data;
    end
  end

  assign head_data = mem[head];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: owns the fetch PC, issues single-outstanding memory requests and
// queues returned instructions for decode.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no request outstanding; issue one if queue has room
//   WAIT  | request outstanding; response will be enqueued
//   DROP  | request outstanding but made stale by a redirect; discard it
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [63:0] pc_out
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [63:0]  fetch_pc;
  logic [63:0]  fetch_pc_next;

  logic         push;
  logic         pop;
  logic         clear;
  logic         full;
  logic         empty;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // Next-state, request issue and enqueue decisions; redirect overrides everything.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    imem_req      = 1'b0;
    push          = 1'b0;
    clear         = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (!redirect && !full) begin
            imem_req   = 1'b1;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_valid) begin
            state_next = IDLE;
            if (!redirect) begin
              push          = 1'b1;
              fetch_pc_next = fetch_pc + PC_INC;
            end
          end else if (redirect) begin
            state_next = DROP;
          end
        end
        DROP: begin
          if (imem_valid) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
      if (redirect) begin
        clear         = 1'b1;
        fetch_pc_next = redirect_pc;
      end
    end
  end

  assign pop        = !empty && !stall && !redirect;
  assign push_entry = '{pc: fetch_pc, instr: imem_instr};
  assign imem_addr  = fetch_pc;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty)
  );

  assign instr_valid = !empty;
  assign instr_out   = empty ? NOP : head_entry.instr;
  assign pc_out      = empty ? 64'h0 : head_entry.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a memory model answers requests after a programmable
// latency; requests and dequeued pairs are compared against expectation queues.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_instr = 32'h0;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [63:0] pc_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int n_deq    = 0;
  logic [63:0] last_deq_pc = 64'h0;

  logic [63:0] exp_req_q[$];
  logic [63:0] exp_pc_q[$];
  logic [63:0] exp_a;
  logic [63:0] exp_p;

  int          lat = 1;
  int          rsp_cnt = 0;
  logic [63:0] rsp_addr = 64'h0;
  logic        req_s;
  logic [63:0] addr_s;
  logic [4:0]  pat;

  fetch_queue #(
    .DEPTH(4),
    .RESET_PC(64'h0),
    .NOP(32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] addr);
    return addr[31:0] ^ addr[63:32] ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reseed(input logic [63:0] base);
    exp_req_q.delete();
    exp_pc_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_req_q.push_back(base + 64'(4 * i));
      exp_pc_q.push_back(base + 64'(4 * i));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that samples the next request (DUT now in WAIT).
  task automatic wait_req(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd1);
    tick();
  endtask

  // Memory model: single pending response, returned lat cycles after the request edge.
  always @(posedge clk) begin
    req_s  = imem_req;
    addr_s = imem_addr;
    if (req_s) begin
      rsp_cnt  = lat;
      rsp_addr = addr_s;
    end
    #1;
    imem_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        imem_valid = 1'b1;
        imem_instr = word(rsp_addr);
      end
    end
  end

  // Monitor: every request and every dequeue is matched against the expectation queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req) begin
        n_req = n_req + 1;
        if (exp_req_q.size() == 0) begin
          n_checks = n_checks + 1;
          n_fail   = n_fail + 1;
          $display("FAIL req_unexpected: got addr %0h expected no request", imem_addr);
        end else begin
          exp_a = exp_req_q.pop_front();
          chk("req_addr", imem_addr, exp_a);
        end
      end
      if (instr_valid && !stall && !redirect) begin
        n_deq       = n_deq + 1;
        last_deq_pc = pc_out;
        if (exp_pc_q.size() == 0) begin
          n_checks = n_checks + 1;
          n_fail   = n_fail + 1;
          $display("FAIL deq_unexpected: got pc %0h expected no dequeue", pc_out);
        end else begin
          exp_p = exp_pc_q.pop_front();
          chk("deq_pc", pc_out, exp_p);
          chk("deq_instr", 64'(instr_out), 64'(word(exp_p)));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    stall       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    lat         = 1;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr_out), 64'h13);
    chk("rst_pc", pc_out, 64'h0);

    // Fill under stall: four entries, then no more requests.
    tick();
    reseed(64'h0);
    n_req = 0;
    reset = 1'b0;
    @(negedge clk);
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", imem_addr, 64'h0);
    @(posedge clk);
    #1;
    repeat (9) tick();
    chk("fill_req_count", 64'(n_req), 64'd4);
    @(negedge clk);
    chk("full_no_req", 64'(imem_req), 64'd0);
    chk("full_valid", 64'(instr_valid), 64'd1);
    chk("full_head_pc", pc_out, 64'h0);
    chk("full_head_instr", 64'(instr_out), 64'(word(64'h0)));

    // Release stall: one dequeue per cycle and fetching resumes.
    tick();
    stall = 1'b0;
    n_deq = 0;
    n_req = 0;
    repeat (4) tick();
    chk("drain_count", 64'(n_deq), 64'd4);
    chk("resume_req_count", 64'(n_req), 64'd2);

    // Redirect while waiting on a 3-cycle response.
    lat = 3;
    wait_req("B_wait_req");
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    reseed(64'h100);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("B_drop_valid", 64'(instr_valid), 64'd0);
    chk("B_drop_req", 64'(imem_req), 64'd0);
    tick();
    @(negedge clk);
    chk("B_drop_req2", 64'(imem_req), 64'd0);
    tick();
    @(negedge clk);
    chk("B_new_req", 64'(imem_req), 64'd1);
    chk("B_new_addr", imem_addr, 64'h100);
    n_deq = 0;
    for (int i = 0; i < 30 && n_deq == 0; i++) tick();
    chk("B_deq_seen", 64'(n_deq > 0), 64'd1);
    chk("B_first_pc", last_deq_pc, 64'h100);

    // Redirect in the same cycle as the response.
    lat = 2;
    wait_req("C_wait_req");
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    reseed(64'h200);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("C_req", 64'(imem_req), 64'd1);
    chk("C_addr", imem_addr, 64'h200);
    chk("C_valid", 64'(instr_valid), 64'd0);

    // Redirect coinciding with a would-be dequeue at count 2.
    tick();
    stall = 1'b1;
    lat   = 1;
    repeat (20) tick();
    redirect    = 1'b1;
    redirect_pc = 64'h300;
    reseed(64'h300);
    tick();
    redirect = 1'b0;
    repeat (4) tick();
    redirect    = 1'b1;
    redirect_pc = 64'h400;
    stall       = 1'b0;
    reseed(64'h400);
    @(negedge clk);
    chk("D_pre_valid", 64'(instr_valid), 64'd1);
    chk("D_pre_pc", pc_out, 64'h300);
    chk("D_pre_req", 64'(imem_req), 64'd0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("D_valid", 64'(instr_valid), 64'd0);
    chk("D_instr", 64'(instr_out), 64'h13);
    chk("D_pc", pc_out, 64'h0);
    chk("D_req", 64'(imem_req), 64'd1);
    chk("D_addr", imem_addr, 64'h400);

    // Reset in WAIT at 0x40; the stale response lands in IDLE and must be ignored.
    tick();
    lat         = 2;
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    reseed(64'h40);
    tick();
    redirect = 1'b0;
    wait_req("E_wait_req");
    reset = 1'b1;
    reseed(64'h0);
    tick();
    reset = 1'b0;
    lat   = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat[4-i] = imem_req;
      if (i == 0) chk("E_addr", imem_addr, 64'h0);
    end
    chk("E_req_pattern", 64'(pat), 64'(5'b10101));
    n_deq = 0;
    for (int i = 0; i < 40 && n_deq < 3; i++) tick();
    chk("E_deq3", 64'(n_deq >= 3), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch unit with a small prefetch buffer, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues single-outstanding requests to a variable-latency instruction memory. It queues returned {pc, instr} pairs and presents the oldest one to the decode stage. Branch redirects from the EX stage flush the queue and discard any in-flight response.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 64'h0, fetch PC after reset
- NOP, 32'h00000013, instruction presented when queue empty (addi x0,x0,0)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  one-cycle request pulse; imem_addr valid in same cycle
- imem_addr  out  64  fetch address
- imem_valid  in  1  response strobe, ≥1 cycle after imem_req
- imem_instr  in  32  response data, valid with imem_valid
- redirect  in  1  taken branch (pc_src) from EX
- redirect_pc  in  64  branch target
- stall  in  1  decode not accepting (inverse of IF_ID_write)
- instr_valid  out  1  queue non-empty
- instr_out  out  32  head instruction; NOP when empty
- pc_out  out  64  head PC; 0 when empty

## Operation
- State machine with states IDLE, WAIT and DROP; at most one request outstanding.
- IDLE:
  - If no redirect and count < DEPTH: pulse imem_req with imem_addr = fetch_pc, then go to WAIT.
  - Otherwise stay in IDLE with no request.
- WAIT:
  - On imem_valid: enqueue {fetch_pc, imem_instr}, set fetch_pc += 4 (mod 2^64), go to IDLE.
- DROP:
  - On imem_valid: discard the response, go to IDLE.
- Redirect has the highest priority:
  - Queue is cleared (count = 0, head = tail = 0).
  - fetch_pc is set to redirect_pc.
  - No enqueue or dequeue takes effect that cycle.
- Redirect state transitions:
  - In IDLE: stay in IDLE; no request is issued that cycle.
  - In WAIT without imem_valid: go to DROP.
  - In WAIT or DROP with imem_valid in the same cycle: discard the response, go to IDLE.
  - In DROP without imem_valid: stay in DROP.
- Dequeue happens when instr_valid and not stall and not redirect: head advances and count decrements.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Full queue: no request is issued. A response arriving at count == DEPTH cannot occur, because issue requires count < DEPTH.
- Outputs instr_out and pc_out are combinational from the head entry, muxed to NOP/0 when empty.

## Timing
- Reset values:
  - State IDLE; fetch_pc = RESET_PC.
  - count/head/tail = 0.
  - imem_req = 0, imem_addr = RESET_PC.
  - instr_valid = 0, instr_out = NOP, pc_out = 0.
- First request is issued in the first cycle after reset deasserts.
- Enqueue on the edge where imem_valid is sampled; instr_valid is high in the next cycle.
- With 1-cycle memory, throughput is one instruction per 2 cycles (request, response).
- Redirect sampled at edge N: from cycle N+1 the queue is empty; the earliest new request is at N+1 if the state is IDLE.
- Reset mid-WAIT: return to IDLE. A later stray imem_valid in IDLE is ignored.

## Structure
- Package fetch_pkg contains:
  - the state enum (IDLE, WAIT, DROP);
  - the NOP constant;
  - PC_INC = 64'd4;
  - the entry struct {pc[63:0], instr[31:0]}.
- One sub-module, fetch_fifo:
  - DEPTH-entry circular buffer with head/tail pointers and a clog2(DEPTH)+1-bit count;
  - ports: push, pop, clear, full, empty.
- The top holds the FSM and fetch_pc and drives fetch_fifo.

## Test plan
- Reset, 1-cycle memory returning addr-derived words, stall = 0 -> requests to 0x0, 0x4, 0x8 on alternate cycles; pc_out/instr_out sequence 0x0, 0x4, 0x8 in order.
- Stall held high for 10 cycles -> exactly 4 entries queued, imem_req stays low at count 4; releasing stall drains 0x0..0xC one per cycle and fetching resumes.
- Redirect to 0x100 while in WAIT, response arriving 3 cycles later -> response discarded (DROP); next request address 0x100; first dequeued pc_out = 0x100.
- Redirect and imem_valid in the same cycle -> response not enqueued, queue empty, state IDLE, next request to redirect_pc.
- Redirect in the same cycle as a dequeue with stall = 0 and count = 2 -> count = 0, instr_out = NOP, instr_valid = 0 the next cycle.
- Reset asserted while in WAIT at fetch_pc = 0x40 -> next request to RESET_PC; a late imem_valid after reset is ignored.
